// File: rtl/asg_pkg.sv
// Shared types and helpers for the alternating-step-generator keystream stages.
package asg_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic {
    WARMUP = 1'b0,
    PACK   = 1'b1
  } pack_state_t;

  // Ceiling log2 for elaboration-time sizing; returns 0 for n <= 1.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/asg_sync_fifo.sv
// Single-clock FIFO with pointer-MSB full/empty detection and the head word
// read straight out of storage.
module asg_sync_fifo
  import asg_pkg::*;
#(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = clog2(DEPTH);

  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic [W-1:0] mem [DEPTH];
  logic         do_pop;
  logic         do_push;

  // A full FIFO still takes a word when the head leaves on the same edge.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Pointer update; the extra MSB tells a full ring from an empty one.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write.
  always_ff @(posedge clock) begin
    // NOTE: storage is not reset; the pointers alone define which entries are live.
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  // Stale storage is masked so an empty FIFO (including just after reset) shows zero.
  assign dout  = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/asg_word_packer.sv
// Drops a warm-up prefix of the asg keystream, packs the following nibbles
// MSB-first into words and queues them behind a valid/ready port.
module asg_word_packer
  import asg_pkg::*;
#(
  parameter int WORD_W     = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int DISCARD    = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NIBBLE_W-1:0] asg_in,
  output logic [WORD_W-1:0]   out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                warm,
  output logic                overflow,
  output logic [7:0]          drop_count
);

  localparam int          NIB         = WORD_W / NIBBLE_W;
  localparam int          IW          = clog2(NIB);
  localparam logic [IW-1:0] LAST_IDX  = IW'(NIB - 1);
  localparam logic [7:0]  LAST_WCNT   = 8'((DISCARD == 0) ? 0 : DISCARD - 1);
  localparam pack_state_t RESET_STATE = (DISCARD == 0) ? PACK : WARMUP;

  pack_state_t              state;
  logic [7:0]               wcnt;
  logic [IW-1:0]            nib_idx;
  // Only the leading NIB-1 nibbles are held; the last one joins straight from asg_in.
  logic [WORD_W-1:NIBBLE_W] pack_q;

  logic              word_done;
  logic [WORD_W-1:0] word;
  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic              drop;

  assign word_done = reset && (state == PACK) && (nib_idx == LAST_IDX);
  assign word      = {pack_q, asg_in};
  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;
  assign drop      = word_done && fifo_full && !pop;

  // Warm-up / pack sequencing: one nibble consumed every cycle, never stalled.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state   <= RESET_STATE;
      wcnt    <= '0;
      nib_idx <= '0;
      pack_q  <= '0;
      warm    <= 1'b0;
    end else begin
      case (state)
        WARMUP: begin
          wcnt <= wcnt + 8'd1;
          if (wcnt == LAST_WCNT) begin
            state <= PACK;
            warm  <= 1'b1;
          end
        end
        PACK: begin
          warm <= 1'b1;
          if (nib_idx == LAST_IDX) begin
            nib_idx <= '0;
          end else begin
            pack_q[WORD_W-1-NIBBLE_W*int'(nib_idx) -: NIBBLE_W] <= asg_in;
            nib_idx <= nib_idx + 1'b1;
          end
        end
        default: state <= RESET_STATE;
      endcase
    end
  end

  // Sticky overflow flag and saturating count of words lost to a full FIFO.
  always_ff @(posedge clock) begin
    if (!reset) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
    end
  end

  asg_sync_fifo #(
    .W     (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (word_done),
    .din   (word),
    .pop   (pop),
    .dout  (out_data),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_asg_word_packer.sv
// Self-checking bench: directed tables and sequences plus random traffic,
// all checked against a queue-based reference model of the packer.
module tb_asg_word_packer;

  localparam int W1    = 16;
  localparam int DEPTH = 4;
  localparam int DISC  = 8;
  localparam int NIB1  = W1 / 4;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  // Default-parameter instance
  logic          rst1, rdy1;
  logic [3:0]    asg1;
  logic [W1-1:0] data1;
  logic          valid1, warm1, ovf1;
  logic [7:0]    drops1;

  // WORD_W=8, DISCARD=0 instance
  logic          rst2, rdy2;
  logic [3:0]    asg2;
  logic [7:0]    data2;
  logic          valid2, warm2, ovf2;
  logic [7:0]    drops2;

  asg_word_packer #(.WORD_W(W1), .FIFO_DEPTH(DEPTH), .DISCARD(DISC)) dut1 (
    .clock(clock), .reset(rst1), .asg_in(asg1), .out_data(data1), .out_valid(valid1),
    .out_ready(rdy1), .warm(warm1), .overflow(ovf1), .drop_count(drops1));

  asg_word_packer #(.WORD_W(8), .FIFO_DEPTH(4), .DISCARD(0)) dut2 (
    .clock(clock), .reset(rst2), .asg_in(asg2), .out_data(data2), .out_valid(valid2),
    .out_ready(rdy2), .warm(warm2), .overflow(ovf2), .drop_count(drops2));

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int          m_sampled;
  logic [15:0] m_acc;
  int          m_nib;
  logic [15:0] m_q[$];
  logic        m_ovf;
  int          m_drops;

  task automatic model_edge(input logic rst, input logic [3:0] nib, input logic rdy);
    bit          pop;
    logic [15:0] w;
    if (!rst) begin
      m_sampled = 0; m_acc = '0; m_nib = 0; m_q.delete(); m_ovf = 1'b0; m_drops = 0;
      return;
    end
    pop = rdy && (m_q.size() > 0);
    if (pop) void'(m_q.pop_front());
    if (m_sampled >= DISC) begin
      m_acc = (m_acc << 4) | 16'(nib);
      m_nib++;
      if (m_nib == NIB1) begin
        m_nib = 0;
        w = m_acc;
        if (m_q.size() < DEPTH) m_q.push_back(w);
        else begin
          m_ovf = 1'b1;
          if (m_drops < 255) m_drops++;
        end
      end
    end
    m_sampled++;
  endtask

  // One clock on dut1 with the model advanced in lockstep and all outputs compared.
  task automatic cycle1();
    logic exp_valid;
    model_edge(rst1, asg1, rdy1);
    @(posedge clock);
    #1;
    exp_valid = (m_q.size() > 0);
    check("model valid", 32'(valid1), 32'(exp_valid));
    if (exp_valid) check("model data", 32'(data1), 32'(m_q[0]));
    else if (!rst1) check("reset data", 32'(data1), 32'd0);
    check("model warm", 32'(warm1), 32'((m_sampled > 0) && (m_sampled >= DISC)));
    check("model overflow", 32'(ovf1), 32'(m_ovf));
    check("model drop_count", 32'(drops1), 32'(m_drops));
  endtask

  task automatic reset1();
    rst1 = 1'b0;
    cycle1();
    rst1 = 1'b1;
  endtask

  // Advance dut1 with the counting driver until n nibbles have been sampled.
  task automatic run_to(input int n);
    while (m_sampled < n) begin
      asg1 = 4'(m_sampled % 16);
      cycle1();
    end
  endtask

  typedef struct {
    int          n;
    logic        rdy;
    logic        exp_warm;
    logic        exp_valid;
    logic [15:0] exp_data;
  } vec_t;

  vec_t v1[8];
  vec_t v2[4];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    v1[0] = '{7,  1'b1, 1'b0, 1'b0, 16'h0000};
    v1[1] = '{8,  1'b1, 1'b1, 1'b0, 16'h0000};
    v1[2] = '{11, 1'b1, 1'b1, 1'b0, 16'h0000};
    v1[3] = '{12, 1'b1, 1'b1, 1'b1, 16'h89AB};
    v1[4] = '{13, 1'b1, 1'b1, 1'b0, 16'h0000};
    v1[5] = '{16, 1'b1, 1'b1, 1'b1, 16'hCDEF};
    v1[6] = '{20, 1'b1, 1'b1, 1'b1, 16'h0123};
    v1[7] = '{24, 1'b1, 1'b1, 1'b1, 16'h4567};
    v2[0] = '{1, 1'b1, 1'b1, 1'b0, 16'h0000};
    v2[1] = '{2, 1'b1, 1'b1, 1'b1, 16'h0001};
    v2[2] = '{4, 1'b1, 1'b1, 1'b1, 16'h0023};
    v2[3] = '{6, 1'b1, 1'b1, 1'b1, 16'h0045};

    rst1 = 1'b0; rdy1 = 1'b0; asg1 = '0;
    rst2 = 1'b0; rdy2 = 1'b0; asg2 = '0;
    m_q.delete();

    // 1: warm-up and first words, free-flowing consumer
    reset1();
    check("reset valid", 32'(valid1), 32'd0);
    check("reset warm", 32'(warm1), 32'd0);
    foreach (v1[i]) begin
      rdy1 = v1[i].rdy;
      run_to(v1[i].n);
      check("t1 warm", 32'(warm1), 32'(v1[i].exp_warm));
      check("t1 valid", 32'(valid1), 32'(v1[i].exp_valid));
      if (v1[i].exp_valid) check("t1 data", 32'(data1), 32'(v1[i].exp_data));
    end

    // 2: backpressure, overflow on the fifth word, then drain in order
    reset1();
    rdy1 = 1'b0;
    run_to(20);
    check("t2 held data", 32'(data1), 32'h89AB);
    run_to(28);
    check("t2 overflow", 32'(ovf1), 32'd1);
    check("t2 drop_count", 32'(drops1), 32'd1);
    check("t2 head", 32'(data1), 32'h89AB);
    rdy1 = 1'b1;
    run_to(29); check("t2 pop1", 32'(data1), 32'hCDEF);
    run_to(30); check("t2 pop2", 32'(data1), 32'h0123);
    run_to(31); check("t2 pop3", 32'(data1), 32'h4567);

    // 3: full FIFO with a pop on the completion edge keeps the word
    reset1();
    rdy1 = 1'b0;
    run_to(27);
    rdy1 = 1'b1;
    run_to(28);
    rdy1 = 1'b0;
    check("t3 drop_count", 32'(drops1), 32'd0);
    check("t3 overflow", 32'(ovf1), 32'd0);
    check("t3 head", 32'(data1), 32'hCDEF);
    run_to(32);
    check("t3 still full", 32'(drops1), 32'd1);

    // 4: drop counter saturation
    reset1();
    rdy1 = 1'b0;
    run_to(DISC + NIB1 * 300);
    check("t4 drop_count", 32'(drops1), 32'd255);
    check("t4 overflow", 32'(ovf1), 32'd1);
    check("t4 head", 32'(data1), 32'h89AB);

    // 5: reset in the middle of a word discards everything
    reset1();
    rdy1 = 1'b0;
    run_to(13);
    check("t5 buffered", 32'(valid1), 32'd1);
    rst1 = 1'b0;
    cycle1();
    check("t5 valid", 32'(valid1), 32'd0);
    check("t5 data", 32'(data1), 32'd0);
    check("t5 warm", 32'(warm1), 32'd0);
    rst1 = 1'b1;
    rdy1 = 1'b1;
    run_to(12);
    check("t5 first valid", 32'(valid1), 32'd1);
    check("t5 first word", 32'(data1), 32'h89AB);

    // Random nibbles, bursty consumer and occasional resets against the model
    reset1();
    for (int c = 0; c < 800; c++) begin
      asg1 = 4'($urandom_range(0, 15));
      rdy1 = ($urandom_range(0, 3) != 0) && (((c / 64) % 3) != 1);
      rst1 = ($urandom_range(0, 199) != 0);
      cycle1();
    end
    rst1 = 1'b1;

    // 6: WORD_W=8, DISCARD=0
    rst2 = 1'b0;
    rdy2 = 1'b1;
    @(posedge clock); #1;
    check("t6 reset warm", 32'(warm2), 32'd0);
    check("t6 reset valid", 32'(valid2), 32'd0);
    check("t6 reset data", 32'(data2), 32'd0);
    rst2 = 1'b1;
    begin
      int n2;
      n2 = 0;
      foreach (v2[i]) begin
        rdy2 = v2[i].rdy;
        while (n2 < v2[i].n) begin
          asg2 = 4'(n2 % 16);
          @(posedge clock); #1;
          n2++;
        end
        check("t6 warm", 32'(warm2), 32'(v2[i].exp_warm));
        check("t6 valid", 32'(valid2), 32'(v2[i].exp_valid));
        if (v2[i].exp_valid) check("t6 data", 32'(data2), 32'(v2[i].exp_data[7:0]));
      end
    end
    check("t6 overflow", 32'(ovf2), 32'd0);
    check("t6 drop_count", 32'(drops2), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
